// File: rtl/regfile_wb_ctrl.sv
// Write-port controller for the 32x32 register file: round-robin writeback
// arbitration, registered write stage and pending-write scoreboard.
module regfile_wb_ctrl #(
   parameter int unsigned NUM_SRC = 2
) (
   input  logic                      aclk,
   input  logic                      resetn,
   input  logic                      issue_valid,
   input  logic [4:0]                issue_rd,
   output logic                      issue_ready,
   input  logic [4:0]                chk_rs1,
   input  logic [4:0]                chk_rs2,
   output logic                      rs1_busy,
   output logic                      rs2_busy,
   input  logic [NUM_SRC-1:0]        wb_valid,
   input  logic [5*NUM_SRC-1:0]      wb_rd,
   input  logic [32*NUM_SRC-1:0]     wb_data,
   output logic [NUM_SRC-1:0]        wb_ready,
   output logic                      rf_write_en,
   output logic [4:0]                rf_rd,
   output logic [31:0]               rf_rd_data,
   output logic [5:0]                pending_cnt,
   output logic                      err_unexp_wb
);

   localparam int unsigned RW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned NREG = 32;
   localparam int unsigned CW   = 6;
   localparam int unsigned GW   = (NUM_SRC > 2) ? 2 : 1;

   logic [NREG-1:0]    r_busy;
   logic [GW-1:0]      r_last_grant;
   logic               r_wr_en;
   logic [RW-1:0]      r_rf_rd;
   logic [DW-1:0]      r_rf_data;
   logic [CW-1:0]      r_pending_cnt;
   logic               r_err;

   logic [NREG-1:0]    w_busy_nxt;
   logic [GW-1:0]      w_cand;
   logic [GW-1:0]      w_grant_idx;
   logic               w_grant_vld;
   logic [NUM_SRC-1:0] w_grant;
   logic [RW-1:0]      w_sel_rd;
   logic [DW-1:0]      w_sel_data;
   logic               w_issue_fire;
   logic               w_unexp;

   function automatic logic [CW-1:0] popcnt(input logic [NREG-1:0] v);
      logic [CW-1:0] c;
      c = '0;
      for (int i = 0; i < NREG; i++) begin
         c = c + CW'(v[i]);
      end
      return c;
   endfunction

   // Round-robin search starting one past the last granted requester
   always_comb begin
      w_grant_vld = 1'b0;
      w_grant_idx = '0;
      w_cand      = '0;
      w_grant     = '0;
      for (int unsigned k = 1; k <= NUM_SRC; k++) begin
         w_cand = GW'((32'(r_last_grant) + k) % NUM_SRC);
         if (!w_grant_vld && wb_valid[w_cand]) begin
            w_grant_vld = 1'b1;
            w_grant_idx = w_cand;
         end
      end
      if (!resetn) begin
         w_grant_vld = 1'b0;
      end
      if (w_grant_vld) begin
         w_grant[w_grant_idx] = 1'b1;
      end
   end

   always_comb begin
      w_sel_rd   = '0;
      w_sel_data = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (w_grant_idx == GW'(i)) begin
            w_sel_rd   = wb_rd[i*RW +: RW];
            w_sel_data = wb_data[i*DW +: DW];
         end
      end
   end

   assign wb_ready     = w_grant;
   assign issue_ready  = resetn && ((issue_rd == '0) || !r_busy[issue_rd]);
   assign w_issue_fire = issue_valid && issue_ready && (issue_rd != '0);
   assign rs1_busy     = (chk_rs1 != '0) && r_busy[chk_rs1];
   assign rs2_busy     = (chk_rs2 != '0) && r_busy[chk_rs2];

   // A write to a register nobody is waiting on is flagged but still performed
   assign w_unexp = w_grant_vld && (w_sel_rd != '0) && !r_busy[w_sel_rd] &&
                    !(r_wr_en && (r_rf_rd == w_sel_rd));

   // Clear on regfile commit, set on issue; the two never hit the same bit
   always_comb begin
      w_busy_nxt = r_busy;
      if (r_wr_en) begin
         w_busy_nxt[r_rf_rd] = 1'b0;
      end
      if (w_issue_fire) begin
         w_busy_nxt[issue_rd] = 1'b1;
      end
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge aclk) begin
      if (!resetn) begin
         r_busy        <= '0;
         r_pending_cnt <= '0;
         r_wr_en       <= 1'b0;
         r_rf_rd       <= '0;
         r_rf_data     <= '0;
         r_err         <= 1'b0;
         r_last_grant  <= GW'(NUM_SRC - 1);
      end else begin
         r_busy        <= w_busy_nxt;
         r_pending_cnt <= popcnt(w_busy_nxt);
         r_wr_en       <= w_grant_vld && (w_sel_rd != '0);
         if (w_grant_vld) begin
            r_rf_rd      <= w_sel_rd;
            r_rf_data    <= w_sel_data;
            r_last_grant <= w_grant_idx;
         end
         if (w_unexp) begin
            r_err <= 1'b1;
         end
      end
   end

   assign rf_write_en  = r_wr_en;
   assign rf_rd        = r_rf_rd;
   assign rf_rd_data   = r_rf_data;
   assign pending_cnt  = r_pending_cnt;
   assign err_unexp_wb = r_err;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Directed self-checking bench for regfile_wb_ctrl with two writeback requesters.
module tb_regfile_wb_ctrl;

   logic        aclk = 1'b0;
   logic        resetn;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        issue_ready;
   logic [4:0]  chk_rs1;
   logic [4:0]  chk_rs2;
   logic        rs1_busy;
   logic        rs2_busy;
   logic [1:0]  wb_valid;
   logic [9:0]  wb_rd;
   logic [63:0] wb_data;
   logic [1:0]  wb_ready;
   logic        rf_write_en;
   logic [4:0]  rf_rd;
   logic [31:0] rf_rd_data;
   logic [5:0]  pending_cnt;
   logic        err_unexp_wb;

   int n_checks = 0;
   int n_errors = 0;

   regfile_wb_ctrl #(.NUM_SRC(2)) dut (
      .aclk        (aclk),
      .resetn      (resetn),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .issue_ready (issue_ready),
      .chk_rs1     (chk_rs1),
      .chk_rs2     (chk_rs2),
      .rs1_busy    (rs1_busy),
      .rs2_busy    (rs2_busy),
      .wb_valid    (wb_valid),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .wb_ready    (wb_ready),
      .rf_write_en (rf_write_en),
      .rf_rd       (rf_rd),
      .rf_rd_data  (rf_rd_data),
      .pending_cnt (pending_cnt),
      .err_unexp_wb(err_unexp_wb)
   );

   always #5 aclk = ~aclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   logic [4:0] q0 [2];
   logic [4:0] q1 [2];
   int         i0, i1, lg;
   logic [1:0] exp_gr;
   logic [4:0] gr_rd;
   logic       v0, v1;

   initial begin
      resetn      = 1'b0;
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      chk_rs1     = 5'd5;
      chk_rs2     = 5'd0;
      wb_valid    = 2'b11;
      wb_rd       = {5'd4, 5'd3};
      wb_data     = '0;

      // reset state, with requests presented that must be ignored
      tick(); tick(); tick();
      check("rst_issue_ready", 32'(issue_ready), 32'd0);
      check("rst_wb_ready", 32'(wb_ready), 32'd0);
      check("rst_wr_en", 32'(rf_write_en), 32'd0);
      check("rst_pending", 32'(pending_cnt), 32'd0);
      check("rst_err", 32'(err_unexp_wb), 32'd0);
      check("rst_rs1_busy", 32'(rs1_busy), 32'd0);

      resetn      = 1'b1;
      wb_valid    = 2'b00;
      issue_valid = 1'b1;
      issue_rd    = 5'd5;
      #1;
      check("t1_issue_ready", 32'(issue_ready), 32'd1);
      tick();
      issue_valid = 1'b0;
      check("t1_rs1_busy", 32'(rs1_busy), 32'd1);
      check("t1_rs2_x0", 32'(rs2_busy), 32'd0);
      check("t1_pending", 32'(pending_cnt), 32'd1);
      wb_valid = 2'b01;
      wb_rd    = {5'd0, 5'd5};
      wb_data  = {32'd0, 32'hDEADBEEF};
      #1;
      check("t1_wb_ready", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 2'b00;
      check("t1_wr_en", 32'(rf_write_en), 32'd1);
      check("t1_rf_rd", 32'(rf_rd), 32'd5);
      check("t1_rf_data", rf_rd_data, 32'hDEADBEEF);
      check("t1_busy_commit", 32'(rs1_busy), 32'd1);
      tick();
      check("t1_wr_en_off", 32'(rf_write_en), 32'd0);
      check("t1_busy_clr", 32'(rs1_busy), 32'd0);
      check("t1_pending_clr", 32'(pending_cnt), 32'd0);
      check("t1_rd_hold", 32'(rf_rd), 32'd5);

      // two requesters together; requester 0 was granted last, so 1 goes first
      issue_valid = 1'b1;
      issue_rd    = 5'd3;
      tick();
      issue_rd = 5'd4;
      tick();
      issue_valid = 1'b0;
      check("t2_pending", 32'(pending_cnt), 32'd2);
      wb_valid = 2'b11;
      wb_rd    = {5'd4, 5'd3};
      wb_data  = {32'h4444_0004, 32'h3333_0003};
      #1;
      check("t2_gnt_a", 32'(wb_ready), 32'd2);
      tick();
      wb_valid = 2'b01;
      check("t2_wr_a", 32'(rf_write_en), 32'd1);
      check("t2_rd_a", 32'(rf_rd), 32'd4);
      check("t2_data_a", rf_rd_data, 32'h4444_0004);
      #1;
      check("t2_gnt_b", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 2'b00;
      check("t2_wr_b", 32'(rf_write_en), 32'd1);
      check("t2_rd_b", 32'(rf_rd), 32'd3);
      check("t2_pending_b", 32'(pending_cnt), 32'd1);
      tick();
      check("t2_wr_off", 32'(rf_write_en), 32'd0);
      check("t2_pending_0", 32'(pending_cnt), 32'd0);

      // fairness: both requesters keep requesting
      for (int r = 10; r <= 13; r++) begin
         issue_valid = 1'b1;
         issue_rd    = 5'(r);
         tick();
      end
      issue_valid = 1'b0;
      check("t3_pending", 32'(pending_cnt), 32'd4);
      q0[0] = 5'd10; q0[1] = 5'd12;
      q1[0] = 5'd11; q1[1] = 5'd13;
      i0 = 0; i1 = 0; lg = 0;
      for (int c = 0; c < 4; c++) begin
         v0 = (i0 < 2);
         v1 = (i1 < 2);
         wb_valid = {v1, v0};
         wb_rd    = {v1 ? q1[i1 % 2] : 5'd0, v0 ? q0[i0 % 2] : 5'd0};
         #1;
         if (v1 && (!v0 || lg == 0)) exp_gr = 2'b10;
         else                        exp_gr = 2'b01;
         check("t3_gnt", 32'(wb_ready), 32'(exp_gr));
         if (exp_gr == 2'b10) begin
            gr_rd = q1[i1 % 2]; i1++; lg = 1;
         end else begin
            gr_rd = q0[i0 % 2]; i0++; lg = 0;
         end
         tick();
         check("t3_wr_en", 32'(rf_write_en), 32'd1);
         check("t3_rf_rd", 32'(rf_rd), 32'(gr_rd));
      end
      wb_valid = 2'b00;
      tick();
      check("t3_wr_off", 32'(rf_write_en), 32'd0);
      check("t3_pending_0", 32'(pending_cnt), 32'd0);
      check("t3_no_err", 32'(err_unexp_wb), 32'd0);

      // WAW blocking and retry after the clearing commit
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      chk_rs1     = 5'd7;
      tick();
      check("t4_pending", 32'(pending_cnt), 32'd1);
      check("t4_refuse", 32'(issue_ready), 32'd0);
      tick();
      check("t4_pending_keep", 32'(pending_cnt), 32'd1);
      wb_valid = 2'b01;
      wb_rd    = {5'd0, 5'd7};
      wb_data  = {32'd0, 32'h0000_0777};
      #1;
      check("t4_gnt", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 2'b00;
      check("t4_commit_wr", 32'(rf_write_en), 32'd1);
      check("t4_commit_refuse", 32'(issue_ready), 32'd0);
      tick();
      check("t4_retry_ready", 32'(issue_ready), 32'd1);
      check("t4_retry_pend0", 32'(pending_cnt), 32'd0);
      tick();
      issue_valid = 1'b0;
      check("t4_reissued", 32'(rs1_busy), 32'd1);
      check("t4_reissued_cnt", 32'(pending_cnt), 32'd1);
      wb_valid = 2'b10;
      wb_rd    = {5'd7, 5'd0};
      #1;
      check("t4_gnt2", 32'(wb_ready), 32'd2);
      tick();
      wb_valid = 2'b00;
      tick();
      check("t4_pending_end", 32'(pending_cnt), 32'd0);
      check("t4_no_err", 32'(err_unexp_wb), 32'd0);

      // rd=0 is consumed without a write; non-pending rd raises the sticky error
      wb_valid = 2'b01;
      wb_rd    = {5'd0, 5'd0};
      wb_data  = {32'd0, 32'h0BAD_0000};
      #1;
      check("t5_x0_gnt", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 2'b00;
      check("t5_x0_no_wr", 32'(rf_write_en), 32'd0);
      check("t5_x0_no_err", 32'(err_unexp_wb), 32'd0);
      wb_valid = 2'b01;
      wb_rd    = {5'd0, 5'd9};
      wb_data  = {32'd0, 32'h9999_0009};
      #1;
      check("t5_r9_gnt", 32'(wb_ready), 32'd1);
      tick();
      wb_valid = 2'b00;
      check("t5_err_set", 32'(err_unexp_wb), 32'd1);
      check("t5_r9_wr", 32'(rf_write_en), 32'd1);
      check("t5_r9_rd", 32'(rf_rd), 32'd9);
      check("t5_r9_data", rf_rd_data, 32'h9999_0009);
      tick();
      check("t5_err_sticky", 32'(err_unexp_wb), 32'd1);
      check("t5_pending", 32'(pending_cnt), 32'd0);

      // reset in the write cycle following a grant
      issue_valid = 1'b1;
      issue_rd    = 5'd20;
      chk_rs1     = 5'd20;
      tick();
      issue_valid = 1'b0;
      issue_rd    = 5'd3;
      wb_valid    = 2'b01;
      wb_rd       = {5'd0, 5'd20};
      wb_data     = {32'd0, 32'h1234_5678};
      #1;
      check("t6_gnt", 32'(wb_ready), 32'd1);
      tick();
      check("t6_wr_pre", 32'(rf_write_en), 32'd1);
      resetn = 1'b0;
      #1;
      check("t6_rst_wb_ready", 32'(wb_ready), 32'd0);
      check("t6_rst_issue_ready", 32'(issue_ready), 32'd0);
      tick();
      check("t6_wr_off", 32'(rf_write_en), 32'd0);
      check("t6_pending", 32'(pending_cnt), 32'd0);
      check("t6_err_clr", 32'(err_unexp_wb), 32'd0);
      check("t6_rf_rd", 32'(rf_rd), 32'd0);
      check("t6_rf_data", rf_rd_data, 32'd0);
      check("t6_rs1_busy", 32'(rs1_busy), 32'd0);
      check("t6_wb_ready_hold", 32'(wb_ready), 32'd0);
      tick();
      wb_valid = 2'b00;
      resetn   = 1'b1;
      #1;
      check("t6_post_ready", 32'(issue_ready), 32'd1);
      check("t6_post_busy", 32'(rs1_busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
